// File: rtl/hex_seg_pkg.sv
// Shared 7-segment constants and types for the hex display paths.
// Codes are active-low, bit 6 = segment g down to bit 0 = segment a.
package hex_seg_pkg;

  localparam int NIB_W = 4;
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0011000;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  typedef struct packed {
    logic             is_hex;
    logic             is_dash;
    logic [NIB_W-1:0] nibble;
  } seg_dec_t;

  // Forward mapping, shared with the display decoder.
  function automatic logic [SEG_W-1:0] nib_to_seg(
    input logic [NIB_W-1:0] nib
  );
    logic [SEG_W-1:0] s;
    s = SEG_BLANK;
    unique case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_to_hex_collector_if.sv
// Segment-in / word-out handshake bundle for the collector.
// master drives codes and word acceptance; slave is the collector.
interface seg_to_hex_collector_if
  import hex_seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int ERR_W  = 8
);

  localparam int WORD_W = NIB_W * DIGITS;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  logic [SEG_W-1:0]  SEG_IN;
  logic              SEG_VALID;
  logic              SEG_READY;
  logic [WORD_W-1:0] WORD_OUT;
  logic              WORD_VALID;
  logic              WORD_READY;
  logic [CNT_W-1:0]  DIGIT_CNT;
  logic              ERR_PULSE;
  logic [ERR_W-1:0]  ERR_CNT;

  modport master (
    output SEG_IN,
    output SEG_VALID,
    input  SEG_READY,
    input  WORD_OUT,
    input  WORD_VALID,
    output WORD_READY,
    input  DIGIT_CNT,
    input  ERR_PULSE,
    input  ERR_CNT
  );

  modport slave (
    input  SEG_IN,
    input  SEG_VALID,
    output SEG_READY,
    output WORD_OUT,
    output WORD_VALID,
    input  WORD_READY,
    output DIGIT_CNT,
    output ERR_PULSE,
    output ERR_CNT
  );

endinterface

// File: rtl/seg_to_nibble.sv
// Combinational 7-segment to nibble decoder.
// Flags hex digits and the dash terminator; anything else is invalid.
module seg_to_nibble
  import hex_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output seg_dec_t         dec
);

  // Table lookup; unrecognised codes leave both flags low.
  always_comb begin
    dec = '0;
    unique case (seg)
      SEG_0:    dec = '{1'b1, 1'b0, 4'h0};
      SEG_1:    dec = '{1'b1, 1'b0, 4'h1};
      SEG_2:    dec = '{1'b1, 1'b0, 4'h2};
      SEG_3:    dec = '{1'b1, 1'b0, 4'h3};
      SEG_4:    dec = '{1'b1, 1'b0, 4'h4};
      SEG_5:    dec = '{1'b1, 1'b0, 4'h5};
      SEG_6:    dec = '{1'b1, 1'b0, 4'h6};
      SEG_7:    dec = '{1'b1, 1'b0, 4'h7};
      SEG_8:    dec = '{1'b1, 1'b0, 4'h8};
      SEG_9:    dec = '{1'b1, 1'b0, 4'h9};
      SEG_A:    dec = '{1'b1, 1'b0, 4'hA};
      SEG_B:    dec = '{1'b1, 1'b0, 4'hB};
      SEG_C:    dec = '{1'b1, 1'b0, 4'hC};
      SEG_D:    dec = '{1'b1, 1'b0, 4'hD};
      SEG_E:    dec = '{1'b1, 1'b0, 4'hE};
      SEG_F:    dec = '{1'b1, 1'b0, 4'hF};
      SEG_DASH: dec = '{1'b0, 1'b1, 4'h0};
      default:  dec = '0;
    endcase
  end

endmodule

// File: rtl/seg_to_hex_collector.sv
// Collects decoded 7-segment digits MSB-first into a word.
// A dash flushes a partial word; bad codes are counted and dropped.
module seg_to_hex_collector
  import hex_seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int ERR_W  = 8
)(
  input logic                  CLK,
  input logic                  RESET,
  seg_to_hex_collector_if.slave bus
);

  localparam int WORD_W = NIB_W * DIGITS;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  state_t            state;
  state_t            state_nx;
  seg_dec_t          dec;
  logic [WORD_W-1:0] shift;
  logic [WORD_W-1:0] shifted;
  logic [WORD_W-1:0] word;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ERR_W-1:0]  err_cnt;
  logic              err_pulse;
  logic              seg_ready;
  logic              word_valid;
  logic              xfer;
  logic              full;
  logic              ack;

  seg_to_nibble u_dec (
    .seg (bus.SEG_IN),
    .dec (dec)
  );

  generate
    if (DIGITS == 1) begin : g_one
      assign shifted = dec.nibble;
    end else begin : g_many
      assign shifted = {shift[WORD_W-NIB_W-1:0], dec.nibble};
    end
  endgenerate

  assign xfer    = bus.SEG_VALID && (state == COLLECT);
  assign ack     = (state == HOLD) && bus.WORD_READY;
  assign cnt_inc = cnt + 1'b1;
  assign full    = (cnt_inc == CNT_W'(DIGITS));

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= COLLECT;
    else       state <= state_nx;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nx   = state;
    seg_ready  = 1'b0;
    word_valid = 1'b0;
    unique case (state)
      COLLECT: begin
        seg_ready = 1'b1;
        if (xfer && dec.is_hex && full)
          state_nx = HOLD;
        else if (xfer && dec.is_dash && cnt != '0)
          state_nx = HOLD;
      end
      HOLD: begin
        word_valid = 1'b1;
        if (bus.WORD_READY)
          state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  // Shift register, output word and digit count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      shift <= '0;
      word  <= '0;
      cnt   <= '0;
    end else if (xfer && dec.is_hex) begin
      shift <= shifted;
      cnt   <= cnt_inc;
      if (full) word <= shifted;
    end else if (xfer && dec.is_dash) begin
      if (cnt != '0) word <= shift;
    end else if (ack) begin
      shift <= '0;
      cnt   <= '0;
    end
  end

  // Invalid-code pulse and saturating counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (xfer && !dec.is_hex && !dec.is_dash) begin
        err_pulse <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign bus.SEG_READY  = seg_ready;
  assign bus.WORD_VALID = word_valid;
  assign bus.WORD_OUT   = word;
  assign bus.DIGIT_CNT  = cnt;
  assign bus.ERR_PULSE  = err_pulse;
  assign bus.ERR_CNT    = err_cnt;

endmodule

// File: tb/tb_seg_to_hex_collector.sv
// Directed vector bench for seg_to_hex_collector (DIGITS=4, ERR_W=8).
// Each row: inputs before an edge, expected outputs 1 time unit after.
module tb_seg_to_hex_collector;

  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0011000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SDASH = 7'b0111111;
  localparam logic [6:0] SBLNK = 7'b1111111;
  localparam logic [6:0] SBAD  = 7'b1010101;

  typedef struct {
    string       name;
    logic        rst;
    logic        v;
    logic [6:0]  seg;
    logic        wr;
    logic        sr;
    logic        wv;
    logic [2:0]  cnt;
    logic        ep;
    logic [7:0]  ec;
    logic        cw;
    logic [15:0] word;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;
  vec_t tab[$];

  seg_to_hex_collector_if #(.DIGITS(4), .ERR_W(8)) bus();

  seg_to_hex_collector #(.DIGITS(4), .ERR_W(8)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(string name, logic r, logic v, logic [6:0] seg,
                     logic wr, logic sr, logic wv, logic [2:0] cnt,
                     logic ep, logic [7:0] ec, logic cw, logic [15:0] word);
    vec_t t;
    t.name = name; t.rst = r; t.v = v; t.seg = seg; t.wr = wr;
    t.sr = sr; t.wv = wv; t.cnt = cnt; t.ep = ep; t.ec = ec;
    t.cw = cw; t.word = word;
    tab.push_back(t);
  endtask

  task automatic apply(vec_t t);
    logic [31:0] act;
    logic [31:0] exp;
    logic [15:0] w;
    rst            = t.rst;
    bus.SEG_VALID  = t.v;
    bus.SEG_IN     = t.seg;
    bus.WORD_READY = t.wr;
    @(posedge clk);
    #1;
    w   = t.cw ? bus.WORD_OUT : 16'h0;
    act = {2'b0, bus.SEG_READY, bus.WORD_VALID, bus.DIGIT_CNT,
           bus.ERR_PULSE, bus.ERR_CNT, w};
    exp = {2'b0, t.sr, t.wv, t.cnt, t.ep, t.ec, t.word};
    check(t.name, act, exp);
  endtask

  int split;
  int pulses;

  initial begin
    rst = 1'b1;
    bus.SEG_VALID  = 1'b0;
    bus.SEG_IN     = SBLNK;
    bus.WORD_READY = 1'b0;

    //   name      rst v seg   wr sr wv cnt ep ec cw word
    add("reset",    1, 0, SBLNK, 0, 1, 0, 0, 0, 0, 1, 16'h0);
    add("t1_d1",    0, 1, S1,    0, 1, 0, 1, 0, 0, 0, 16'h0);
    add("t1_d2",    0, 1, S2,    0, 1, 0, 2, 0, 0, 0, 16'h0);
    add("t1_d3",    0, 1, S3,    0, 1, 0, 3, 0, 0, 0, 16'h0);
    add("t1_word",  0, 1, S4,    0, 0, 1, 4, 0, 0, 1, 16'h1234);
    for (int i = 0; i < 10; i++)
      add("t2_hold", 0, 1, S5,   0, 0, 1, 4, 0, 0, 1, 16'h1234);
    add("t2_ack",   0, 1, S5,    1, 1, 0, 0, 0, 0, 0, 16'h0);
    add("t2_idle",  0, 0, S5,    1, 1, 0, 0, 0, 0, 0, 16'h0);
    add("t3_a",     0, 1, SA,    1, 1, 0, 1, 0, 0, 0, 16'h0);
    add("t3_b",     0, 1, SB,    1, 1, 0, 2, 0, 0, 0, 16'h0);
    add("t3_dash",  0, 1, SDASH, 1, 0, 1, 2, 0, 0, 1, 16'h00AB);
    add("t3_once",  0, 0, SDASH, 1, 1, 0, 0, 0, 0, 0, 16'h0);
    add("t4_dash0", 0, 1, SDASH, 0, 1, 0, 0, 0, 0, 0, 16'h0);
    add("t4_bad",   0, 1, SBLNK, 0, 1, 0, 0, 1, 1, 0, 16'h0);
    add("t4_9",     0, 1, S9,    0, 1, 0, 1, 0, 1, 0, 16'h0);
    add("t4_8",     0, 1, S8,    0, 1, 0, 2, 0, 1, 0, 16'h0);
    add("t4_7",     0, 1, S7,    0, 1, 0, 3, 0, 1, 0, 16'h0);
    add("t4_6",     0, 1, S6,    0, 0, 1, 4, 0, 1, 1, 16'h9876);
    add("t4_ack",   0, 0, S6,    1, 1, 0, 0, 0, 1, 0, 16'h0);
    split = tab.size();
    add("t6_f",     0, 1, SF,    0, 1, 0, 1, 0, 255, 0, 16'h0);
    add("t6_e",     0, 1, SE,    0, 1, 0, 2, 0, 255, 0, 16'h0);
    add("t6_rst",   1, 1, SD,    0, 1, 0, 0, 0, 0, 1, 16'h0);
    add("t6_f2",    0, 1, SF,    0, 1, 0, 1, 0, 0, 0, 16'h0);
    add("t6_e2",    0, 1, SE,    0, 1, 0, 2, 0, 0, 0, 16'h0);
    add("t6_d2",    0, 1, SD,    0, 1, 0, 3, 0, 0, 0, 16'h0);
    add("t6_c2",    0, 1, SC,    0, 0, 1, 4, 0, 0, 1, 16'hFEDC);
    add("t6_ack",   0, 0, SC,    1, 1, 0, 0, 0, 0, 0, 16'h0);
    add("t7_a",     0, 1, SA,    0, 1, 0, 1, 0, 0, 0, 16'h0);
    add("t7_b",     0, 1, SB,    0, 1, 0, 2, 0, 0, 0, 16'h0);
    add("t7_dash",  0, 1, SDASH, 0, 0, 1, 2, 0, 0, 1, 16'h00AB);
    add("t7_rst",   1, 0, SDASH, 0, 1, 0, 0, 0, 0, 1, 16'h0);
    add("t7_after", 0, 1, S3,    0, 1, 0, 1, 0, 0, 0, 16'h0);

    for (int i = 0; i < split; i++) apply(tab[i]);

    // Long run of invalid codes: counter must saturate, pulses continue.
    pulses = 0;
    rst = 1'b0;
    bus.WORD_READY = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.SEG_VALID = 1'b1;
      bus.SEG_IN    = (i % 2 == 0) ? SBAD : SBLNK;
      @(posedge clk);
      #1;
      if (bus.ERR_PULSE === 1'b1) pulses++;
    end
    check("t5_pulses", 32'(pulses), 32'd300);
    check("t5_errcnt", 32'(bus.ERR_CNT), 32'd255);
    check("t5_digits", 32'(bus.DIGIT_CNT), 32'd0);
    bus.SEG_VALID = 1'b0;
    @(posedge clk);
    #1;
    check("t5_pulse_end", {31'b0, bus.ERR_PULSE}, 32'd0);
    check("t5_sat_hold", 32'(bus.ERR_CNT), 32'd255);

    for (int i = split; i < tab.size(); i++) apply(tab[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg_to_hex_collector.md
Name: seg_to_hex_collector

Overview:
Inverse of the team's nibble-to-7-segment decoder. It accepts a stream of active-low 7-segment codes over a valid/ready handshake and decodes each code back to a 4-bit hex nibble. It packs DIGITS nibbles MSB-first into a word and presents that word on a second valid/ready handshake. It sits between the display-pattern path (capture or loopback of HEX drive) and the notepad text buffer, and is used for self-check and pattern readback.

Parameters:
DIGITS, 4, number of nibbles per output word (1..8).
ERR_W, 8, width of the saturating invalid-pattern counter.

Ports:
CLK  in  1  single system clock; all logic is on the rising edge.
RESET  in  1  synchronous, active-high reset.
SEG_IN  in  7  active-low segment code, same bit mapping as the display decoder output.
SEG_VALID  in  1  SEG_IN holds a code this cycle.
SEG_READY  out  1  block can accept a code this cycle.
WORD_OUT  out  4*DIGITS  assembled word; first-received nibble is most significant.
WORD_VALID  out  1  WORD_OUT is valid.
WORD_READY  in  1  downstream accepts WORD_OUT.
DIGIT_CNT  out  clog2(DIGITS+1)  nibbles collected so far in the current word.
ERR_PULSE  out  1  one-cycle pulse when an unrecognised code is accepted.
ERR_CNT  out  ERR_W  saturating count of unrecognised codes.

Behaviour:
- Clocking and reset: one clock; RESET is synchronous and active-high.
- Reset values: state COLLECT, SEG_READY=1, WORD_OUT=0, WORD_VALID=0, DIGIT_CNT=0, ERR_PULSE=0, ERR_CNT=0. Registers take these values on the first CLK edge with RESET=1.
- RESET mid-word discards collected nibbles. RESET during HOLD drops WORD_VALID on the same edge.
- Decode table (SEG_IN -> nibble):
  1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7,
  0000000->8, 0011000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F.
- 0111111 is the DASH code and acts as a terminator. Any other code is invalid.
- A transfer occurs when SEG_VALID && SEG_READY at a rising edge. SEG_IN is ignored when there is no transfer.
- States:
  - COLLECT: SEG_READY=1, WORD_VALID=0.
  - HOLD: SEG_READY=0, WORD_VALID=1.
- COLLECT, valid hex code transferred:
  - Shift register = {shift[4*DIGITS-5:0], nibble}; DIGIT_CNT+1.
  - If the new count equals DIGITS, go to HOLD on the same edge and load WORD_OUT with the completed shift value.
  - WORD_VALID is high in the cycle after the last digit's transfer edge (1-cycle latency).
- COLLECT, DASH transferred:
  - DIGIT_CNT>0: flush the partial word right-aligned with zero upper nibbles into WORD_OUT and go to HOLD.
  - DIGIT_CNT==0: no effect.
- COLLECT, invalid code transferred:
  - Code is consumed and discarded; shift register and DIGIT_CNT are unchanged.
  - ERR_PULSE=1 for exactly the next cycle.
  - ERR_CNT increments and saturates at 2^ERR_W-1 (no wrap).
- HOLD:
  - WORD_OUT and DIGIT_CNT are stable until WORD_VALID && WORD_READY at an edge.
  - On that edge: go to COLLECT, DIGIT_CNT=0, clear the shift register. WORD_OUT keeps its last value and is don't-care while WORD_VALID=0.
  - The earliest next SEG transfer is the following edge; one bubble cycle is intended.
- WORD_READY may already be high when WORD_VALID rises. The handshake then completes on the first HOLD edge, so WORD_VALID is high for exactly one cycle.
- WORD_VALID must never drop without a handshake, except on RESET.
- ERR_PULSE and ERR_CNT are independent of WORD_READY. They can only change in COLLECT, since no transfers occur in HOLD.

Decomposition:
- Package hex_seg_pkg holds:
  - the 16 segment constants SEG_0..SEG_F, plus SEG_DASH=0111111 and SEG_BLANK=1111111;
  - NIB_W=4 and SEG_W=7.
  - The existing display decoder is to be migrated onto these constants.
- Sub-module seg_to_nibble: combinational, maps SEG_IN to {is_hex, is_dash, nibble}, using a case over the package constants.
- The FSM, shift register and counters live in seg_to_hex_collector.

Test Plan:
1. Reset, then SEG codes for 1,2,3,4 on consecutive cycles with WORD_READY=0 -> WORD_OUT=16'h1234 and WORD_VALID=1 one cycle after the 4th transfer; SEG_READY=0; DIGIT_CNT=4.
2. Continue from 1, hold WORD_READY=0 for 10 cycles while driving SEG_VALID=1 -> WORD_OUT stable, no transfers. Then WORD_READY=1 for one cycle -> next cycle WORD_VALID=0, SEG_READY=1, DIGIT_CNT=0.
3. Codes A, B, DASH with WORD_READY=1 -> WORD_OUT=16'h00AB, WORD_VALID high for exactly one cycle.
4. DASH at DIGIT_CNT=0 -> no word. Then 1111111 -> ERR_PULSE for one cycle, ERR_CNT=1, DIGIT_CNT=0. Then 9,8,7,6 -> 16'h9876.
5. 300 consecutive invalid codes -> ERR_CNT=255 (saturated) and 300 ERR_PULSE cycles.
6. Codes F, E, then RESET=1 for one cycle, then F, E, D, C -> DIGIT_CNT=0 after reset; the only word produced is 16'hFEDC.
